// File: rtl/alu_display_pkg.sv
// Shared types and constants for the ALU result display.
// Digit codes carry a decimal value or one of two special glyphs.
package alu_display_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_e;

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_MINUS = 7'h3F;

    // Bit 4 set marks a non-numeric glyph; bits 3:0 hold 0-9 otherwise.
    typedef logic [4:0] digit_t;

    localparam digit_t DIG_BLANK = 5'h10;
    localparam digit_t DIG_MINUS = 5'h11;

    function automatic digit_t dig_num(input logic [3:0] n);
        return {1'b0, n};
    endfunction

endpackage

// File: rtl/bcd_to_7seg.sv
// Digit code to active-low segment pattern {g,f,e,d,c,b,a}.
// Unused codes render as blank.
import alu_display_pkg::*;

module bcd_to_7seg (
    input  digit_t     code_i,
    output logic [6:0] seg_o
);

    always_comb begin
        seg_o = SEG_BLANK;
        case (code_i)
            5'h00:     seg_o = 7'h40;
            5'h01:     seg_o = 7'h79;
            5'h02:     seg_o = 7'h24;
            5'h03:     seg_o = 7'h30;
            5'h04:     seg_o = 7'h19;
            5'h05:     seg_o = 7'h12;
            5'h06:     seg_o = 7'h02;
            5'h07:     seg_o = 7'h78;
            5'h08:     seg_o = 7'h00;
            5'h09:     seg_o = 7'h10;
            DIG_MINUS: seg_o = SEG_MINUS;
            default:   seg_o = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/alu_result_display.sv
// Captures an ALU result, converts it to BCD by double-dabble and
// scans it onto four multiplexed active-low 7-segment digits.
import alu_display_pkg::*;

module alu_result_display #(
    parameter int REFRESH_DIV = 50000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic       signed_en,
    input  logic [7:0] result,
    input  logic [3:0] flags_in,
    output logic [6:0] seg,
    output logic [3:0] an,
    output logic [3:0] flags_led,
    output logic       busy,
    output logic       done
);

    localparam int RW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [RW-1:0] R_LAST = RW'(REFRESH_DIV - 1);

    state_e      state_q;
    logic [2:0]  cnt_q;
    logic [11:0] bcd_q;
    logic [11:0] bcd_d;
    logic [11:0] adj;
    logic [7:0]  mag_q;
    logic [7:0]  mag_d;
    logic [7:0]  mag_cap;
    logic [3:0]  r4;
    logic        neg_q;
    logic [3:0]  flags_q;
    logic        busy_q;
    logic        done_q;
    digit_t      disp_q [4];

    logic [3:0]  hund;
    logic [3:0]  tens;
    logic [3:0]  ones;

    logic [RW-1:0] rcnt_q;
    logic [1:0]    idx_q;
    logic [6:0]    seg_q;
    logic [3:0]    an_q;
    digit_t        cur_dig;
    logic [6:0]    seg_mux;

    // Signed mode shows the low nibble as two's complement; -8 maps to 8.
    always_comb begin
        r4      = result[3:0];
        mag_cap = result;
        if (signed_en) begin
            mag_cap = {4'd0, r4[3] ? (4'd0 - r4) : r4};
        end
    end

    always_comb begin
        adj = bcd_q;
        for (int i = 0; i < 3; i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5) begin
                adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
            end
        end
        {bcd_d, mag_d} = {adj, mag_q} << 1;
    end

    assign hund = bcd_q[11:8];
    assign tens = bcd_q[7:4];
    assign ones = bcd_q[3:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            bcd_q     <= '0;
            mag_q     <= '0;
            neg_q     <= 1'b0;
            flags_q   <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            disp_q[3] <= DIG_BLANK;
            disp_q[2] <= DIG_BLANK;
            disp_q[1] <= DIG_BLANK;
            disp_q[0] <= dig_num(4'd0);
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (load) begin
                        flags_q <= flags_in;
                        mag_q   <= mag_cap;
                        neg_q   <= signed_en & result[3];
                        bcd_q   <= '0;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= SHIFT;
                    end
                end
                SHIFT: begin
                    bcd_q <= bcd_d;
                    mag_q <= mag_d;
                    cnt_q <= cnt_q + 3'd1;
                    if (cnt_q == 3'd7) begin
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    disp_q[3] <= neg_q ? DIG_MINUS : DIG_BLANK;
                    disp_q[2] <= (hund == 4'd0) ? DIG_BLANK : dig_num(hund);
                    disp_q[1] <= (hund == 4'd0 && tens == 4'd0)
                                 ? DIG_BLANK : dig_num(tens);
                    disp_q[0] <= dig_num(ones);
                    done_q    <= 1'b0;
                    busy_q    <= 1'b0;
                    state_q   <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign cur_dig = disp_q[idx_q];

    bcd_to_7seg u_seg (
        .code_i (cur_dig),
        .seg_o  (seg_mux)
    );

    // Slot shown on a wrap is the current index; the index then advances.
    always_ff @(posedge clk) begin
        if (rst) begin
            rcnt_q <= '0;
            idx_q  <= '0;
            seg_q  <= SEG_BLANK;
            an_q   <= 4'hF;
        end else if (rcnt_q == R_LAST) begin
            rcnt_q <= '0;
            idx_q  <= idx_q + 2'd1;
            seg_q  <= seg_mux;
            an_q   <= ~(4'b0001 << idx_q);
        end else begin
            rcnt_q <= rcnt_q + 1'b1;
        end
    end

    assign seg       = seg_q;
    assign an        = an_q;
    assign flags_led = flags_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

// File: tb/tb_alu_result_display.sv
// Directed bench: vector table of loads plus reset/refresh/ignore sequences.
module tb_alu_result_display;

    localparam int DIV = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       load;
    logic       signed_en;
    logic [7:0] result;
    logic [3:0] flags_in;
    logic [6:0] seg;
    logic [3:0] an;
    logic [3:0] flags_led;
    logic       busy;
    logic       done;

    int errors = 0;
    int checks = 0;

    alu_result_display #(.REFRESH_DIV(DIV)) dut (
        .clk       (clk),
        .rst       (rst),
        .load      (load),
        .signed_en (signed_en),
        .result    (result),
        .flags_in  (flags_in),
        .seg       (seg),
        .an        (an),
        .flags_led (flags_led),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    typedef struct {
        logic [7:0] res;
        logic       sen;
        logic [3:0] fl;
        logic [6:0] d3;
        logic [6:0] d2;
        logic [6:0] d1;
        logic [6:0] d0;
    } vec_t;

    vec_t tbl [10];

    task automatic chk(input string name, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_load(input logic [7:0] r, input logic s,
                           input logic [3:0] f);
        result    = r;
        signed_en = s;
        flags_in  = f;
        load      = 1'b1;
        tick();
        load      = 1'b0;
    endtask

    // Called just after the capture edge; measures busy length and done slot.
    task automatic run_conv(input string name);
        int bc;
        int dpos;
        bc   = 0;
        dpos = -1;
        for (int k = 0; k < 20; k++) begin
            if (!busy) break;
            bc++;
            if (done) dpos = k + 1;
            tick();
        end
        chk({name, " busy_len"}, bc, 9);
        chk({name, " done_pos"}, dpos, 9);
        chk({name, " done_low"}, done, 1'b0);
    endtask

    task automatic scan(output logic [27:0] digs);
        logic [27:0] acc;
        acc = 'x;
        repeat (4 * DIV) tick();
        repeat (4 * DIV) begin
            tick();
            case (an)
                4'b1110: acc[6:0]   = seg;
                4'b1101: acc[13:7]  = seg;
                4'b1011: acc[20:14] = seg;
                4'b0111: acc[27:21] = seg;
                default: ;
            endcase
        end
        digs = acc;
    endtask

    task automatic chk_digs(input string name, input logic [27:0] got,
                            input logic [27:0] exp);
        chk({name, " sign"}, got[27:21], exp[27:21]);
        chk({name, " hund"}, got[20:14], exp[20:14]);
        chk({name, " tens"}, got[13:7], exp[13:7]);
        chk({name, " ones"}, got[6:0], exp[6:0]);
    endtask

    initial begin
        logic [27:0] digs;
        logic [3:0]  exp_an;
        int          n;

        tbl[0] = '{8'd225, 1'b0, 4'b0000, 7'h7F, 7'h24, 7'h24, 7'h12};
        tbl[1] = '{8'h0D,  1'b1, 4'b0001, 7'h3F, 7'h7F, 7'h7F, 7'h30};
        tbl[2] = '{8'h08,  1'b1, 4'b0100, 7'h3F, 7'h7F, 7'h7F, 7'h00};
        tbl[3] = '{8'd0,   1'b0, 4'b1000, 7'h7F, 7'h7F, 7'h7F, 7'h40};
        tbl[4] = '{8'd100, 1'b0, 4'b0110, 7'h7F, 7'h79, 7'h40, 7'h40};
        tbl[5] = '{8'd255, 1'b0, 4'b1111, 7'h7F, 7'h24, 7'h12, 7'h12};
        tbl[6] = '{8'h07,  1'b1, 4'b0010, 7'h7F, 7'h7F, 7'h7F, 7'h78};
        tbl[7] = '{8'd9,   1'b0, 4'b0011, 7'h7F, 7'h7F, 7'h7F, 7'h10};
        tbl[8] = '{8'hF5,  1'b1, 4'b1001, 7'h7F, 7'h7F, 7'h7F, 7'h12};
        tbl[9] = '{8'd74,  1'b0, 4'b0101, 7'h7F, 7'h7F, 7'h78, 7'h19};

        rst       = 1'b1;
        load      = 1'b0;
        signed_en = 1'b0;
        result    = '0;
        flags_in  = '0;
        repeat (3) tick();
        chk("reset seg", seg, 7'h7F);
        chk("reset an", an, 4'hF);
        chk("reset busy", busy, 1'b0);
        chk("reset done", done, 1'b0);
        chk("reset led", flags_led, 4'h0);
        rst = 1'b0;

        for (int i = 1; i <= 20; i++) begin
            tick();
            exp_an = (i < 4) ? 4'hF : ~(4'b0001 << ((i / 4 - 1) % 4));
            chk($sformatf("refresh an @%0d", i), an, exp_an);
            if (i == 4) chk("first wrap seg", seg, 7'h40);
        end

        for (int v = 0; v < 10; v++) begin
            do_load(tbl[v].res, tbl[v].sen, tbl[v].fl);
            run_conv($sformatf("vec%0d", v));
            chk($sformatf("vec%0d led", v), flags_led, tbl[v].fl);
            scan(digs);
            chk_digs($sformatf("vec%0d", v), digs,
                     {tbl[v].d3, tbl[v].d2, tbl[v].d1, tbl[v].d0});
        end

        do_load(8'd225, 1'b0, 4'b0000);
        tick();
        tick();
        do_load(8'h0D, 1'b1, 4'b0001);
        n = 0;
        while (busy && n < 20) begin
            tick();
            n++;
        end
        chk("ignored load remaining busy", n, 6);
        chk("ignored load led", flags_led, 4'b0000);
        scan(digs);
        chk_digs("ignored load", digs, {7'h7F, 7'h24, 7'h24, 7'h12});

        do_load(8'd100, 1'b0, 4'b1010);
        repeat (3) tick();
        chk("pre-reset busy", busy, 1'b1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midreset busy", busy, 1'b0);
        chk("midreset done", done, 1'b0);
        chk("midreset seg", seg, 7'h7F);
        chk("midreset an", an, 4'hF);
        chk("midreset led", flags_led, 4'h0);
        repeat (10) tick();
        chk("midreset stays idle", busy, 1'b0);
        scan(digs);
        chk_digs("midreset", digs, {7'h7F, 7'h7F, 7'h7F, 7'h40});

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
